// File: rtl/crossbar_seq_ctrl.sv
// crossbar_seq_ctrl
// Sequences SET / RESET / READ pulses onto one cell of a resistive crossbar.
// The block is configured through a Wishbone classic slave that occupies a
// 16-byte window at BASE_ADR.
// Optional feature: define CBAR_WRITE_VERIFY_EN to compile in the write-verify
// loop. That loop reads back after each SET/RESET and retries up to 3 times.
//
// Ports:
//   wb_clk_i, wb_rst_n_i     clock, asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i     Wishbone classic controls
//   wbs_sel_i/adr_i/dat_i    byte lanes, address, write data
//   wbs_ack_o, wbs_dat_o     acknowledge (one cycle after request), read data
//   sense_i                  sense comparator, asynchronous to wb_clk_i
//   row_sel_o, col_sel_o     one-hot word-line / bit-line selects
//   set_en_o/rst_en_o/rd_en_o  drive enables, only ever high in PULSE
//   irq_o                    done & irq enable
//
// Registers (adr[3:2]):
//   0 CTRL   (W)     [1:0] op, [8:4] row, [16:12] col, [31:24] pulse width
//   1 STATUS (R/W1C) [0] busy, [1] done, [2] err, [3] verify_fail
//   2 RESULT (R)     [0] last sensed bit, [15:8] retries used
//   3 IRQEN  (R/W)   [0] irq enable
//
// state   | meaning
// IDLE    | no operation, selects and enables low
// SETUP   | selects driven, enables low, one cycle
// PULSE   | enable for current op high for the timer length
// SAMPLE  | two cycles, synchronised sense stored in the last one
// RECOVER | two cycles all low, then done
module crossbar_seq_ctrl #(
    parameter int unsigned ROWS     = 8,
    parameter int unsigned COLS     = 8,
    parameter int unsigned PW_BITS  = 8,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic            sense_i,
    output logic [ROWS-1:0] row_sel_o,
    output logic [COLS-1:0] col_sel_o,
    output logic            set_en_o,
    output logic            rst_en_o,
    output logic            rd_en_o,
    output logic            irq_o
);
    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_SET   = 2'd1;
    localparam logic [1:0] OP_RESET = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_SAMPLE, S_RECOVER} state_t;
    state_t state, state_nxt;

    logic               ack_q;
    logic [31:0]        dat_q, rdata;
    logic [1:0]         op_q;
    logic [4:0]         row_q, col_q;
    logic [7:0]         width_q;
    logic               done_q, err_q, vfail_q, irqen_q, result_q;
    logic               sync1_q, sync2_q;
    logic [PW_BITS-1:0] cnt_q, cnt_val;
    logic               cnt_load, sample_store, op_done, set_vfail;
    logic               acc, wr, wr_ctrl, busy, fields_ok, start, bad_ctrl, w1c;
    logic               pulse, sel_on;
    logic [1:0]         reg_idx;
    logic [31:0]        ctrl_old, ctrl_new;
    logic               verify_q;
    logic [7:0]         retry_q;
    logic               unused_bits;

    // Request is taken only when no ack is pending, so a master that holds
    // stb through the ack cycle still sees exactly one ack per access.
    assign acc     = wbs_cyc_i & wbs_stb_i & ~ack_q & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
    assign wr      = acc & wbs_we_i;
    assign reg_idx = wbs_adr_i[3:2];
    assign busy    = (state != S_IDLE);
    assign wr_ctrl = wr & (reg_idx == 2'd0);
    assign w1c     = wr & (reg_idx == 2'd1) & wbs_sel_i[0];

    // Byte lanes not written keep the previously latched CTRL fields.
    assign ctrl_old = {width_q, 7'd0, col_q, 3'd0, row_q, 2'd0, op_q};
    always_comb begin
        ctrl_new = ctrl_old;
        for (int i = 0; i < 4; i++) begin
            if (wbs_sel_i[i]) ctrl_new[8*i +: 8] = wbs_dat_i[8*i +: 8];
        end
    end

    assign fields_ok = (ctrl_new[1:0] != OP_RSVD) && (32'(ctrl_new[8:4]) < ROWS) &&
                       (32'(ctrl_new[16:12]) < COLS) && (ctrl_new[31:24] != 8'd0);
    assign start     = wr_ctrl & ~busy & fields_ok;
    assign bad_ctrl  = wr_ctrl & (busy | ~fields_ok);

    always_comb begin
        rdata = 32'd0;
        case (reg_idx)
            2'd1:    rdata = {28'd0, vfail_q, err_q, done_q, busy};
            2'd2:    rdata = {16'd0, retry_q, 7'd0, result_q};
            2'd3:    rdata = {31'd0, irqen_q};
            default: rdata = 32'd0;
        endcase
    end

`ifdef CBAR_WRITE_VERIFY_EN
    logic verify_begin, retry_inc;
`endif

    always_comb begin
        state_nxt    = state;
        cnt_load     = 1'b0;
        cnt_val      = '0;
        sample_store = 1'b0;
        op_done      = 1'b0;
        set_vfail    = 1'b0;
`ifdef CBAR_WRITE_VERIFY_EN
        verify_begin = 1'b0;
        retry_inc    = 1'b0;
`endif
        case (state)
            S_IDLE: if (start) state_nxt = S_SETUP;
            S_SETUP: begin
                // A verify read-back uses a fixed one-cycle pulse.
                state_nxt = S_PULSE;
                cnt_load  = 1'b1;
                cnt_val   = verify_q ? '0 : PW_BITS'(width_q - 8'd1);
            end
            S_PULSE: if (cnt_q == '0) begin
                if ((op_q == OP_READ) || verify_q) begin
                    state_nxt = S_SAMPLE;
                    cnt_load  = 1'b1;
                    cnt_val   = PW_BITS'(1);
                end else begin
`ifdef CBAR_WRITE_VERIFY_EN
                    state_nxt    = S_SETUP;
                    verify_begin = 1'b1;
`else
                    state_nxt = S_RECOVER;
                    cnt_load  = 1'b1;
                    cnt_val   = PW_BITS'(1);
`endif
                end
            end
            S_SAMPLE: if (cnt_q == '0) begin
                sample_store = 1'b1;
                state_nxt    = S_RECOVER;
                cnt_load     = 1'b1;
                cnt_val      = PW_BITS'(1);
`ifdef CBAR_WRITE_VERIFY_EN
                if (verify_q && (sync2_q != (op_q == OP_SET))) begin
                    if (retry_q == 8'd3) begin
                        set_vfail = 1'b1;
                    end else begin
                        state_nxt = S_SETUP;
                        cnt_load  = 1'b0;
                        retry_inc = 1'b1;
                    end
                end
`endif
            end
            S_RECOVER: if (cnt_q == '0) begin
                state_nxt = S_IDLE;
                op_done   = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state    <= S_IDLE;
            ack_q    <= 1'b0;
            dat_q    <= 32'd0;
            op_q     <= 2'd0;
            row_q    <= 5'd0;
            col_q    <= 5'd0;
            width_q  <= 8'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            vfail_q  <= 1'b0;
            irqen_q  <= 1'b0;
            result_q <= 1'b0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state   <= state_nxt;
            ack_q   <= acc;
            dat_q   <= (acc & ~wbs_we_i) ? rdata : 32'd0;
            sync1_q <= sense_i;
            sync2_q <= sync1_q;
            if (cnt_load)           cnt_q <= cnt_val;
            else if (cnt_q != '0)   cnt_q <= cnt_q - PW_BITS'(1);
            if (start) begin
                op_q    <= ctrl_new[1:0];
                row_q   <= ctrl_new[8:4];
                col_q   <= ctrl_new[16:12];
                width_q <= ctrl_new[31:24];
            end
            if (wr && (reg_idx == 2'd3) && wbs_sel_i[0]) irqen_q <= wbs_dat_i[0];
            // A completion in the same cycle as a W1C clear wins.
            if (op_done)                               done_q <= 1'b1;
            else if (start || (w1c && wbs_dat_i[1]))   done_q <= 1'b0;
            if (bad_ctrl)                  err_q <= 1'b1;
            else if (w1c && wbs_dat_i[2])  err_q <= 1'b0;
            if (set_vfail)                 vfail_q <= 1'b1;
            else if (w1c && wbs_dat_i[3])  vfail_q <= 1'b0;
            if (sample_store) result_q <= sync2_q;
        end
    end

`ifdef CBAR_WRITE_VERIFY_EN
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            verify_q <= 1'b0;
            retry_q  <= 8'd0;
        end else begin
            if (start)              verify_q <= 1'b0;
            else if (verify_begin)  verify_q <= 1'b1;
            else if (retry_inc)     verify_q <= 1'b0;
            if (start)              retry_q <= 8'd0;
            else if (retry_inc)     retry_q <= retry_q + 8'd1;
        end
    end
`else
    assign verify_q = 1'b0;
    assign retry_q  = 8'd0;
`endif

    // Outputs decode straight from state so reset removes drive immediately.
    assign pulse     = (state == S_PULSE);
    assign sel_on    = (state == S_SETUP) || pulse || (state == S_SAMPLE);
    assign row_sel_o = sel_on ? (ROWS'(1) << row_q) : '0;
    assign col_sel_o = sel_on ? (COLS'(1) << col_q) : '0;
    assign rd_en_o   = pulse & ((op_q == OP_READ) | verify_q);
    assign set_en_o  = pulse & (op_q == OP_SET) & ~verify_q;
    assign rst_en_o  = pulse & (op_q == OP_RESET) & ~verify_q;
    assign irq_o     = done_q & irqen_q;
    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

    assign unused_bits = ^{ctrl_new[23:17], ctrl_new[11:9], ctrl_new[3:2], wbs_adr_i[1:0]};
endmodule

// File: tb/tb_crossbar_seq_ctrl.sv
// Self-checking bench for crossbar_seq_ctrl. The reference model predicts
// latency, pulse counts, read-back and status for each operation directly
// from the operation rules.
module tb_crossbar_seq_ctrl;
    localparam logic [31:0] BASE    = 32'h3000_0000;
    localparam logic [31:0] A_CTRL  = BASE;
    localparam logic [31:0] A_STAT  = BASE + 32'h4;
    localparam logic [31:0] A_RES   = BASE + 32'h8;
    localparam logic [31:0] A_IRQEN = BASE + 32'hC;
`ifdef CBAR_WRITE_VERIFY_EN
    localparam int VERIFY = 1;
`else
    localparam int VERIFY = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc, stb, we, sense;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w, dat_r;
    logic        ack, set_en, rst_en, rd_en, irq;
    logic [7:0]  row_sel, col_sel;

    crossbar_seq_ctrl dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_w),
        .wbs_ack_o(ack), .wbs_dat_o(dat_r),
        .sense_i(sense),
        .row_sel_o(row_sel), .col_sel_o(col_sel),
        .set_en_o(set_en), .rst_en_o(rst_en), .rd_en_o(rd_en),
        .irq_o(irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int n_set = 0, n_rst = 0, n_rd = 0, n_overlap = 0, n_selbad = 0;
    int cur_run = 0, last_run = 0;
    logic [7:0] exp_rs = 8'd0, exp_cs = 8'd0;
    logic model_result;

    // Pulse monitor: enable cycle counts, run length, select correctness.
    always @(negedge clk) begin
        if (set_en) n_set++;
        if (rst_en) n_rst++;
        if (rd_en)  n_rd++;
        if ($countones({set_en, rst_en, rd_en}) > 1) n_overlap++;
        if (set_en || rst_en || rd_en) begin
            cur_run++;
            if (row_sel != exp_rs || col_sel != exp_cs) n_selbad++;
        end else if (cur_run != 0) begin
            last_run = cur_run;
            cur_run  = 0;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output logic acked);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        acked = 1'b0;
        rd = 32'd0;
        for (int i = 0; i < 4 && !acked; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                acked = 1'b1;
                rd = dat_r;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        logic ok;
        wb_xfer(a, 1'b1, d, s, rd, ok);
        check_val("wr_ack", ok, 1);
    endtask

    task automatic wb_rd(input logic [31:0] a, output logic [31:0] d);
        logic ok;
        wb_xfer(a, 1'b0, 32'd0, 4'hF, d, ok);
        check_val("rd_ack", ok, 1);
    endtask

    function automatic logic [31:0] ctrl_word(input int op, input int row, input int col, input int w);
        logic [31:0] v;
        v = 32'd0;
        v[1:0]   = op[1:0];
        v[8:4]   = row[4:0];
        v[16:12] = col[4:0];
        v[31:24] = w[7:0];
        return v;
    endfunction

    task automatic wait_irq(output int n);
        n = 0;
        while (!irq && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // One valid operation against the reference model; IRQEN must be 1.
    task automatic run_op(input int op, input int row, input int col, input int w, input logic s);
        int attempts, exp_lat, exp_rd, exp_retry, exp_run, n;
        int s0, r0, d0, o0, b0;
        logic mism;
        logic [31:0] rd;
        sense = s;
        repeat (3) @(posedge clk);
        exp_rs = 8'd1 << row;
        exp_cs = 8'd1 << col;
        mism = (op != 0) && (s != (op == 1));
        attempts  = (VERIFY != 0 && mism) ? 4 : 1;
        if (op == 0) begin
            exp_rd = w;  exp_lat = w + 5;  exp_retry = 0;  exp_run = w;
        end else if (VERIFY != 0) begin
            exp_rd = attempts;  exp_lat = attempts * (w + 5) + 2;
            exp_retry = attempts - 1;  exp_run = 1;
        end else begin
            exp_rd = 0;  exp_lat = w + 3;  exp_retry = 0;  exp_run = w;
        end
        if (op == 0 || VERIFY != 0) model_result = s;
        s0 = n_set; r0 = n_rst; d0 = n_rd; o0 = n_overlap; b0 = n_selbad;
        wb_wr(A_CTRL, ctrl_word(op, row, col, w), 4'hF);
        check_val("setup_sel", {row_sel, col_sel}, {exp_rs, exp_cs});
        check_val("setup_en", {set_en, rst_en, rd_en}, 0);
        wait_irq(n);
        check_val("latency", n, exp_lat);
        check_val("set_cycles", n_set - s0, (op == 1) ? attempts * w : 0);
        check_val("rst_cycles", n_rst - r0, (op == 2) ? attempts * w : 0);
        check_val("rd_cycles", n_rd - d0, exp_rd);
        check_val("last_run", last_run, exp_run);
        check_val("en_overlap", n_overlap - o0, 0);
        check_val("pulse_sel", n_selbad - b0, 0);
        check_val("idle_sel", {row_sel, col_sel}, 0);
        wb_rd(A_RES, rd);
        check_val("result", rd, {16'd0, exp_retry[7:0], 7'd0, model_result});
        wb_rd(A_STAT, rd);
        check_val("status", rd, (VERIFY != 0 && mism) ? 32'hA : 32'h2);
        wb_wr(A_STAT, 32'hF, 4'hF);
        check_val("irq_clr", irq, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic ok;
        int n, e0;
        cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat_w = 0; sense = 0;
        model_result = 1'b0;

        repeat (3) @(posedge clk); #1;
        check_val("rst_outs", {ack, dat_r, row_sel, col_sel, set_en, rst_en, rd_en, irq}, 0);
        @(negedge clk) rst_n = 1'b1;
        wb_rd(A_STAT, rd);  check_val("rst_status", rd, 0);
        wb_rd(A_RES, rd);   check_val("rst_result", rd, 0);
        wb_rd(A_IRQEN, rd); check_val("rst_irqen", rd, 0);

        // Out-of-window accesses and IRQEN byte lanes.
        wb_xfer(BASE + 32'h20, 1'b0, 32'd0, 4'hF, rd, ok);
        check_val("noack_rd", ok, 0);
        wb_xfer(BASE + 32'h20, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, ok);
        check_val("noack_wr", ok, 0);
        wb_rd(A_STAT, rd); check_val("noack_side", rd, 0);
        wb_wr(A_IRQEN, 32'hFFFF_FFFF, 4'b0001);
        wb_rd(A_IRQEN, rd); check_val("irqen_lane0", rd, 1);
        wb_wr(A_IRQEN, 32'h0, 4'b1110);
        wb_rd(A_IRQEN, rd); check_val("irqen_hold", rd, 1);

        run_op(0, 3, 5, 4, 1'b1);
        run_op(1, 2, 6, 10, 1'b0);

        // Writes while busy are rejected; the running READ is unaffected.
        sense = 1'b0;
        repeat (3) @(posedge clk);
        exp_rs = 8'h04; exp_cs = 8'h02;
        e0 = n_set + n_rst;
        n = n_rd;
        wb_wr(A_CTRL, ctrl_word(0, 2, 1, 8), 4'hF);
        wb_wr(A_CTRL, ctrl_word(1, 1, 1, 3), 4'hF);
        wb_wr(A_CTRL, ctrl_word(0, 8, 1, 3), 4'hF);
        e0 = n_set + n_rst - e0;
        check_val("busy_no_wr_pulse", e0, 0);
        wait_irq(e0);
        check_val("busy_rd_cycles", n_rd - n, 8);
        check_val("busy_run", last_run, 8);
        wb_rd(A_STAT, rd); check_val("busy_err_status", rd, 32'h6);
        wb_rd(A_RES, rd);  check_val("busy_result", rd, 0);
        model_result = 1'b0;
        wb_wr(A_STAT, 32'hF, 4'hF);

        // Invalid fields while idle: err, no start.
        for (int k = 0; k < 3; k++) begin
            e0 = n_set + n_rst + n_rd;
            case (k)
                0:       wb_wr(A_CTRL, ctrl_word(3, 1, 1, 4), 4'hF);
                1:       wb_wr(A_CTRL, ctrl_word(1, 1, 8, 4), 4'hF);
                default: wb_wr(A_CTRL, ctrl_word(2, 1, 1, 0), 4'hF);
            endcase
            repeat (6) @(posedge clk);
            wb_rd(A_STAT, rd); check_val("bad_status", rd, 32'h4);
            check_val("bad_no_pulse", n_set + n_rst + n_rd - e0, 0);
            wb_wr(A_STAT, 32'hF, 4'hF);
        end

        // Reset in the third PULSE cycle.
        exp_rs = 8'h10; exp_cs = 8'h40;
        wb_wr(A_CTRL, ctrl_word(1, 4, 6, 10), 4'hF);
        n = 0;
        while (!set_en && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("pulse_seen", set_en, 1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        check_val("pulse3_on", set_en, 1);
        rst_n = 1'b0;
        #1;
        check_val("async_rst", {ack, dat_r, row_sel, col_sel, set_en, rst_en, rd_en, irq}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        model_result = 1'b0;
        wb_rd(A_STAT, rd);  check_val("post_rst_status", rd, 0);
        wb_rd(A_RES, rd);   check_val("post_rst_result", rd, 0);
        wb_rd(A_IRQEN, rd); check_val("post_rst_irqen", rd, 0);
        check_val("post_rst_sel", {row_sel, col_sel}, 0);
        wb_wr(A_IRQEN, 32'h1, 4'hF);

        run_op(2, 1, 1, 3, 1'b1);
        run_op(2, 1, 1, 3, 1'b0);

        for (int k = 0; k < 12; k++) begin
            run_op($urandom_range(2, 0), $urandom_range(7, 0), $urandom_range(7, 0),
                   $urandom_range(12, 1), 1'($urandom_range(1, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
